// File: rtl/aes_pkg.sv
// Shared GF(2^8) arithmetic, round-constant stepping and the controller state type
// for the AES inverse cipher.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, INIT, ROUND} dec_state_t;

  localparam logic [7:0] RCON_FIRST = 8'h01;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
  function automatic logic [7:0] gf_inverse(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    return gf_mul(x240, x14);
  endfunction

  function automatic logic [7:0] rcon_next(input logic [7:0] rcon);
    return xtime(rcon);
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a, b, c, d;
    a = col[31:24];
    b = col[23:16];
    c = col[15:8];
    d = col[7:0];
    return {mul14(a) ^ mul11(b) ^ mul13(c) ^ mul9(d),
            mul9(a)  ^ mul14(b) ^ mul11(c) ^ mul13(d),
            mul13(a) ^ mul9(b)  ^ mul14(c) ^ mul11(d),
            mul11(a) ^ mul13(b) ^ mul9(c)  ^ mul14(d)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Table-free AES S-box: GF(2^8) inversion wrapped by the affine map (forward)
// or preceded by the inverse affine map (inverse).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  input  logic       inv,
  output logic [7:0] y
);

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
  endfunction

  logic [7:0] pre;
  logic [7:0] recip;

  assign pre   = inv ? inv_affine(x) : x;
  assign recip = gf_inverse(pre);
  assign y     = inv ? recip : affine(recip);

endmodule

// File: rtl/aes_decrypt.sv
// Iterative FIPS-197 inverse cipher: expands the key one word per cycle, then
// runs one decryption round per cycle from rk[Nr] down to rk[0].
module aes_decrypt
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [127:0]   in,
  input  logic [N-1:0]   key,
  output logic [127:0]   out,
  output logic           busy,
  output logic           done
);

  localparam int NW = 4 * (Nr + 1);
  localparam logic [5:0] LAST_WORD = 6'(NW - 1);
  localparam logic [5:0] INIT_BASE = 6'(4 * Nr);

  dec_state_t state, state_next;

  logic         accept, expand_en, init_en, round_en, finish;
  logic [5:0]   word_idx;
  logic [3:0]   round_idx;
  logic [2:0]   kcnt;
  logic [7:0]   rcon;
  logic [127:0] in_reg;
  logic [127:0] st;
  logic [31:0]  w [NW];

  logic [31:0]  prev_word, sub_in, sub_out, temp;
  logic [5:0]   rk_base;
  logic [127:0] round_key, init_key;
  logic [127:0] subbed, added, mixed, round_out;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXPAND;
      EXPAND:  if (word_idx == LAST_WORD) state_next = INIT;
      INIT:    state_next = ROUND;
      ROUND:   if (round_idx == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    accept    = 1'b0;
    expand_en = 1'b0;
    init_en   = 1'b0;
    round_en  = 1'b0;
    case (state)
      IDLE:   accept = start;
      EXPAND: begin busy = 1'b1; expand_en = 1'b1; end
      INIT:   begin busy = 1'b1; init_en = 1'b1; end
      ROUND:  begin busy = 1'b1; round_en = 1'b1; end
      default: ;
    endcase
  end

  assign finish = round_en && (round_idx == 4'd0);

  // Key schedule: kcnt tracks i mod Nk so no divider is needed.
  always_comb begin
    prev_word = w[word_idx - 6'd1];
    sub_in    = (kcnt == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    if (kcnt == 3'd0)                   temp = sub_out ^ {rcon, 24'h000000};
    else if (Nk == 8 && kcnt == 3'd4)   temp = sub_out;
    else                                temp = prev_word;
  end

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (.x(sub_in[31-8*j -: 8]), .inv(1'b0), .y(sub_out[31-8*j -: 8]));
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < Nk; j++) w[j] <= key[N-1-32*j -: 32];
    end
    if (expand_en) w[word_idx] <= w[word_idx - 6'(Nk)] ^ temp;
  end

  always_comb begin
    rk_base   = {round_idx, 2'b00};
    round_key = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    init_key  = {w[INIT_BASE], w[INIT_BASE + 6'd1], w[INIT_BASE + 6'd2], w[INIT_BASE + 6'd3]};
  end

  // Byte k sits at row k%4, column k/4; InvShiftRows is folded into the S-box wiring.
  for (genvar k = 0; k < 16; k++) begin : g_inv_sbox
    localparam int R   = k % 4;
    localparam int C   = k / 4;
    localparam int SRC = 4 * ((C - R + 4) % 4) + R;
    aes_sbox u_sbox (.x(st[127-8*SRC -: 8]), .inv(1'b1), .y(subbed[127-8*k -: 8]));
  end

  assign added = subbed ^ round_key;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mixed[127-32*c -: 32] = inv_mix_column(added[127-32*c -: 32]);
  end

  assign round_out = (round_idx == 4'd0) ? added : mixed;

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      done      <= 1'b0;
      word_idx  <= '0;
      round_idx <= '0;
      kcnt      <= '0;
      rcon      <= RCON_FIRST;
      in_reg    <= '0;
      st        <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        in_reg   <= in;
        word_idx <= 6'(Nk);
        kcnt     <= 3'd0;
        rcon     <= RCON_FIRST;
      end
      if (expand_en) begin
        word_idx <= word_idx + 6'd1;
        kcnt     <= (kcnt == 3'(Nk - 1)) ? 3'd0 : kcnt + 3'd1;
        if (kcnt == 3'd0) rcon <= rcon_next(rcon);
      end
      if (init_en) begin
        st        <= in_reg ^ init_key;
        round_idx <= 4'(Nr - 1);
      end
      if (round_en) begin
        st <= round_out;
        if (finish) out <= round_out;
        else        round_idx <= round_idx - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_decrypt.sv
// Scoreboard bench for aes_decrypt at all three key sizes using FIPS-197 vectors.
module tb_aes_decrypt;

  typedef struct {
    logic [127:0] pt;
    int           acc;
    int           lat;
  } exp_t;

  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KB   = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CTB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PTB   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start128 = 1'b0, start192 = 1'b0, start256 = 1'b0;
  logic [127:0] in128 = '0, in192 = '0, in256 = '0;
  logic [127:0] key128 = '0;
  logic [191:0] key192 = '0;
  logic [255:0] key256 = '0;
  logic [127:0] out128, out192, out256;
  logic         busy128, busy192, busy256;
  logic         done128, done192, done256;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q128[$], q192[$], q256[$];

  aes_decrypt #(.N(128), .Nr(10), .Nk(4)) dut128 (
    .clk(clk), .rst(rst), .start(start128), .in(in128), .key(key128),
    .out(out128), .busy(busy128), .done(done128));

  aes_decrypt #(.N(192), .Nr(12), .Nk(6)) dut192 (
    .clk(clk), .rst(rst), .start(start192), .in(in192), .key(key192),
    .out(out192), .busy(busy192), .done(done192));

  aes_decrypt #(.N(256), .Nr(14), .Nk(8)) dut256 (
    .clk(clk), .rst(rst), .start(start256), .in(in256), .key(key256),
    .out(out256), .busy(busy256), .done(done256));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int qsize(input int sel);
    case (sel)
      128:     return q128.size();
      192:     return q192.size();
      default: return q256.size();
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic checkOutput(input int sel, input logic [127:0] got, input logic got_busy);
    exp_t e;
    checks++;
    if (qsize(sel) == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_done_%0d: done=1 at cycle %0d, required no done", sel, cyc);
      return;
    end
    case (sel)
      128:     e = q128.pop_front();
      192:     e = q192.pop_front();
      default: e = q256.pop_front();
    endcase
    check($sformatf("out_%0d", sel), got, e.pt);
    checks++;
    if (cyc - e.acc != e.lat) begin
      errors++;
      $display("[TB] FAIL latency_%0d: got %0d cycles required %0d", sel, cyc - e.acc, e.lat);
    end
    check($sformatf("busy_at_done_%0d", sel), {127'b0, got_busy}, 128'd0);
  endtask

  always @(negedge clk) begin
    if (done128 === 1'b1) checkOutput(128, out128, busy128);
    if (done192 === 1'b1) checkOutput(192, out192, busy192);
    if (done256 === 1'b1) checkOutput(256, out256, busy256);
  end

  // Called at a negedge; start is seen on the next edge, then inputs are scrambled.
  task automatic applyStimulus(input int sel, input logic [255:0] k, input logic [127:0] ct,
                               input logic [127:0] pt, output int acc);
    exp_t e;
    case (sel)
      128:     begin start128 = 1'b1; in128 = ct; key128 = k[127:0]; end
      192:     begin start192 = 1'b1; in192 = ct; key192 = k[191:0]; end
      default: begin start256 = 1'b1; in256 = ct; key256 = k; end
    endcase
    @(posedge clk);
    #1;
    acc   = cyc;
    e.pt  = pt;
    e.acc = acc;
    e.lat = (sel == 128) ? 51 : (sel == 192) ? 59 : 67;
    case (sel)
      128:     q128.push_back(e);
      192:     q192.push_back(e);
      default: q256.push_back(e);
    endcase
    @(negedge clk);
    start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
    in128 = ~in128; in192 = ~in192; in256 = ~in256;
    key128 = ~key128; key192 = ~key192; key256 = ~key256;
  endtask

  task automatic waitDone(input int sel, input int budget);
    int n = 0;
    while (qsize(sel) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (qsize(sel) != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_%0d: no done within %0d cycles, required done", sel, budget);
      case (sel)
        128:     q128.delete();
        192:     q192.delete();
        default: q256.delete();
      endcase
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, acc2;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_128", out128, 128'd0);
    check("reset_out_192", out192, 128'd0);
    check("reset_out_256", out256, 128'd0);
    check("reset_busy_128", {127'b0, busy128}, 128'd0);
    check("reset_busy_192", {127'b0, busy192}, 128'd0);
    check("reset_busy_256", {127'b0, busy256}, 128'd0);
    check("reset_done_128", {127'b0, done128}, 128'd0);
    check("reset_done_192", {127'b0, done192}, 128'd0);
    check("reset_done_256", {127'b0, done256}, 128'd0);
    rst = 1'b0;

    @(negedge clk); applyStimulus(128, K128, CT128, PT, acc); waitDone(128, 80);
    @(negedge clk); applyStimulus(192, K192, CT192, PT, acc); waitDone(192, 80);
    @(negedge clk); applyStimulus(256, K256, CT256, PT, acc); waitDone(256, 90);

    // A start at cycle 10 of a running operation must be ignored.
    @(negedge clk); applyStimulus(128, KB, CTB, PTB, acc);
    repeat (9) @(negedge clk);
    start128 = 1'b1; in128 = CT128; key128 = K128[127:0];
    @(negedge clk);
    start128 = 1'b0;
    check("busy_mid_op", {127'b0, busy128}, 128'd1);
    waitDone(128, 80);
    repeat (70) @(negedge clk);
    check("out_hold", out128, PTB);

    // Reset at cycle 20 aborts with no done; a fresh start then works.
    @(negedge clk); applyStimulus(128, K128, CT128, PT, acc);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q128.delete();
    check("abort_out", out128, 128'd0);
    check("abort_busy", {127'b0, busy128}, 128'd0);
    repeat (70) @(negedge clk);
    @(negedge clk); applyStimulus(128, K128, CT128, PT, acc); waitDone(128, 80);

    // Back-to-back: second start presented in the done cycle.
    @(negedge clk); applyStimulus(128, KB, CTB, PTB, acc);
    repeat (51) @(negedge clk);
    applyStimulus(128, K128, CT128, PT, acc2);
    checks++;
    if (acc2 - acc != 52) begin
      errors++;
      $display("[TB] FAIL back_to_back_accept: got %0d cycles required 52", acc2 - acc);
    end
    waitDone(128, 80);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 SHALL have parameter N, default 128, cipher key width in bits; legal values are 128, 192 and 256.
REQ-002 SHALL have parameter Nr, default 10, round count; legal values are 10, 12 and 14, paired with N.
REQ-003 SHALL have parameter Nk, default 4, key length in 32-bit words; legal values are 4, 6 and 8, paired with N.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL provide port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL provide port start, input, 1 bit: request to begin a decryption.
REQ-008 SHALL provide port in, input, 128 bits: ciphertext block; bits [127:120] are state byte 0, and state bytes fill column-major.
REQ-009 SHALL provide port key, input, N bits: cipher key; bits [N-1:N-8] are key byte 0.
REQ-010 SHALL provide port out, output, 128 bits: plaintext block, with the same byte order as in.
REQ-011 SHALL provide port busy, output, 1 bit: high while an operation is in progress.
REQ-012 SHALL provide port done, output, 1 bit: one-cycle pulse when out becomes valid.

Function
REQ-013 SHALL implement FIPS-197 inverse cipher (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) with the standard key expansion; Nw = 4*(Nr+1).
REQ-014 SHALL sample in and key on a rising edge where start=1 and busy=0 (state IDLE), and SHALL leave later changes to in and key without effect on the operation.
REQ-015 SHALL ignore start while busy=1.
REQ-016 SHALL use states IDLE, EXPAND, INIT, ROUND; IDLE goes to EXPAND on accepted start.
REQ-017 In EXPAND, SHALL generate one key-schedule word per cycle for words Nk..Nw-1, taking Nw-Nk cycles, and store all round keys; words 0..Nk-1 are loaded directly from key at accept.
REQ-018 EXPAND SHALL use RotWord/SubWord/Rcon when i mod Nk = 0, and SHALL use extra SubWord when Nk = 8 and i mod 8 = 4.
REQ-019 INIT SHALL take one cycle: state <= in XOR rk[Nr].
REQ-020 ROUND SHALL run Nr cycles with r = Nr-1 down to 0: state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r]), then InvMixColumns except when r = 0.
REQ-021 After the r = 0 cycle, SHALL load out with state, pulse done for one cycle, drop busy, and return to IDLE.
REQ-022 Latency from the accepting edge to done high SHALL be (Nw-Nk)+1+Nr cycles: 51, 59 and 67 cycles for 128, 192 and 256.
REQ-023 SHALL hold out until the next completion or reset.
REQ-024 SHALL accept a start presented in the done cycle, since that cycle is IDLE.
REQ-025 SHALL keep busy=1 in EXPAND, INIT and ROUND, and 0 otherwise.
REQ-026 SHALL keep GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1, and Rcon SHALL start at 0x01 and be doubled in GF(2^8).

Reset
REQ-027 On a rst=1 edge, SHALL set state to IDLE, out = 0, done = 0, busy = 0, round and word counters = 0.
REQ-028 rst SHALL override a simultaneous start.
REQ-029 rst mid-operation SHALL abort without asserting done.

Structure
REQ-030 SHALL keep the GF multiply helpers (xtime, mul by 9/11/13/14) and Rcon generation in a shared package aes_pkg.
REQ-031 SHALL use one sub-module aes_sbox (8-bit in, 8-bit out, inverse select): GF(2^8) inversion plus affine or inverse-affine, no 256-entry tables.
REQ-032 SHALL instantiate aes_sbox 16 times for the datapath and 4 times for SubWord.

Verification
REQ-033 SHALL check N=128: key 000102030405060708090a0b0c0d0e0f, in 69c4e0d86a7b0430d8cdb78070b4c55a -> out 00112233445566778899aabbccddeeff, with done 51 cycles after start.
REQ-034 SHALL check N=192, Nr=12, Nk=6: key 000102030405060708090a0b0c0d0e0f1011121314151617, in dda97ca4864cdfe06eaf70a0ec0d7191 -> out 00112233445566778899aabbccddeeff, with done at 59 cycles.
REQ-035 SHALL check N=256, Nr=14, Nk=8: key 000102…1e1f, in 8ea2b7ca516745bfeafc49904b496089 -> out 00112233445566778899aabbccddeeff, with done at 67 cycles.
REQ-036 SHALL check a start pulse at cycle 10 of a running 128-bit operation -> ignored; the single done arrives at 51 with the first result.
REQ-037 SHALL check rst at cycle 20 of an operation -> out=0, busy=0, and no done; then a fresh start gives the correct result.
REQ-038 SHALL check back-to-back operation: start asserted in the done cycle with a new vector -> second done 51 cycles later, with out correct for each.
